// File: rtl/dcache_bus_responder_pkg.sv
// Shared definitions for the D-cache bus responder.
//   READ/WRITE : encodings of bus_rw
//   BEATS      : words per cache block (fixed by the line size)
//   BLK_OFF_W  : byte-offset width of a block; these address bits are ignored
//   state_e    : responder FSM states
package dcache_bus_responder_pkg;

  localparam logic READ  = 1'b0;
  localparam logic WRITE = 1'b1;

  localparam int unsigned BEATS      = 16;
  localparam int unsigned BEAT_CNT_W = 5;
  localparam int unsigned BLK_OFF_W  = 6;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StRd,
    StWr,
    StDone
  } state_e;

  // Block-aligned byte address: low offset bits forced to zero.
  function automatic logic [31:0] block_base(input logic [31:0] addr);
    return {addr[31:BLK_OFF_W], {BLK_OFF_W{1'b0}}};
  endfunction

endpackage

// File: rtl/dcache_bus_responder_if.sv
// Simple cache bus between the D-cache (master) and a block memory responder (slave).
//   bus_as      : request strobe (level)
//   bus_rw      : READ block refill / WRITE block write-back
//   bus_rd_addr : block byte address for reads
//   bus_wr_addr : block byte address for writes
//   bus_wr_data : write-back word, sampled in each bus_ready cycle of a write
//   bus_rd_data : refill word, valid in bus_ready cycles of a read
//   bus_ready   : one pulse per beat
interface dcache_bus_responder_if;
  import dcache_bus_responder_pkg::*;

  logic        bus_as;
  logic        bus_rw;
  logic [31:0] bus_rd_addr;
  logic [31:0] bus_wr_addr;
  logic [31:0] bus_wr_data;
  logic [31:0] bus_rd_data;
  logic        bus_ready;

  modport master (
    output bus_as, bus_rw, bus_rd_addr, bus_wr_addr, bus_wr_data,
    input  bus_rd_data, bus_ready
  );

  modport slave (
    input  bus_as, bus_rw, bus_rd_addr, bus_wr_addr, bus_wr_data,
    output bus_rd_data, bus_ready
  );

endinterface

// File: rtl/dcache_bus_responder_sram.sv
// Synchronous single-port word SRAM with byte write enables and 1-cycle read latency.
//   clk_i   : clock
//   en_i    : access enable
//   we_i    : byte write enables; all zero means read
//   addr_i  : word address
//   wdata_i : write data
//   rdata_o : read data, valid the cycle after a read access (held otherwise)
module dcache_bus_responder_sram #(
  parameter int unsigned MEM_AW = 14
) (
  input  logic              clk_i,
  input  logic              en_i,
  input  logic [3:0]        we_i,
  input  logic [MEM_AW-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem_q [2**MEM_AW];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      for (int b = 0; b < 4; b++) begin
        if (we_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
      if (we_i == 4'h0) rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dcache_bus_responder.sv
// Memory-side responder for the D-cache block bus. Serves 16-word block reads (refill) and
// 16-word block writes (write-back) against a synchronous SRAM with 1-cycle read latency.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : cache bus, slave side
//   mem_*      : SRAM port (enable, byte write enables, word address, write/read data)
//   busy       : high from request acceptance until the DONE state is left
// All outputs are registered.
module dcache_bus_responder
  import dcache_bus_responder_pkg::*;
#(
  parameter int unsigned MEM_AW      = 14,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  dcache_bus_responder_if.slave  bus,
  output logic                   mem_en,
  output logic [3:0]             mem_we,
  output logic [MEM_AW-1:0]      mem_addr,
  output logic [31:0]            mem_wdata,
  input  logic [31:0]            mem_rdata,
  output logic                   busy
);

  localparam logic [BEAT_CNT_W-1:0] BeatEnd  = BEAT_CNT_W'(BEATS);
  localparam logic [BEAT_CNT_W-1:0] BeatLast = BEAT_CNT_W'(BEATS - 1);
  localparam logic [3:0]            WaitLast = 4'(WAIT_CYCLES - 1);

  state_e                 state_q, state_d;
  logic                   rw_q, rw_d;
  logic [MEM_AW-1:0]      base_q, base_d;
  logic [3:0]             wait_q, wait_d;
  logic [BEAT_CNT_W-1:0]  iss_q, iss_d;     // SRAM reads issued / ready pulses raised
  logic [BEAT_CNT_W-1:0]  ret_q, ret_d;     // read words returned / SRAM writes issued
  logic                   rd_pend_q, rd_pend_d;
  logic                   rec_valid_q, rec_valid_d;
  logic                   rec_rw_q, rec_rw_d;
  logic [31:0]            rec_addr_q, rec_addr_d;
  logic                   ready_q, ready_d;
  logic [31:0]            rd_data_q, rd_data_d;
  logic                   mem_en_q, mem_en_d;
  logic [3:0]             mem_we_q, mem_we_d;
  logic [MEM_AW-1:0]      mem_addr_q, mem_addr_d;
  logic [31:0]            mem_wdata_q, mem_wdata_d;
  logic                   busy_q, busy_d;

  logic [31:0] req_addr;
  logic        new_req;
  logic        accept;
  logic        start;

  assign req_addr = block_base(bus.bus_rw ? bus.bus_wr_addr : bus.bus_rd_addr);
  // A held request that was already served must not start a second burst.
  assign new_req  = bus.bus_as &&
                    (!rec_valid_q || (bus.bus_rw != rec_rw_q) || (req_addr != rec_addr_q));

  always_comb begin
    state_d     = state_q;
    rw_d        = rw_q;
    base_d      = base_q;
    wait_d      = wait_q;
    iss_d       = iss_q;
    ret_d       = ret_q;
    // SRAM data for a read issued last cycle is on mem_rdata this cycle.
    rd_pend_d   = mem_en_q && (mem_we_q == 4'h0);
    rec_valid_d = rec_valid_q;
    rec_rw_d    = rec_rw_q;
    rec_addr_d  = rec_addr_q;
    busy_d      = busy_q;
    ready_d     = 1'b0;
    rd_data_d   = '0;
    mem_en_d    = 1'b0;
    mem_we_d    = 4'h0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    accept      = 1'b0;
    start       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (new_req) accept = 1'b1;
      end
      StWait: begin
        if (wait_q == WaitLast) start = 1'b1;
        else wait_d = wait_q + 4'd1;
      end
      StRd: begin
        if (iss_q < BeatEnd) begin
          mem_en_d   = 1'b1;
          mem_addr_d = base_q + MEM_AW'(iss_q);
          iss_d      = iss_q + 1'b1;
        end
        if (rd_pend_q) begin
          ready_d   = 1'b1;
          rd_data_d = mem_rdata;
          ret_d     = ret_q + 1'b1;
          if (ret_q == BeatLast) state_d = StDone;
        end
      end
      StWr: begin
        if (iss_q < BeatEnd) begin
          ready_d = 1'b1;
          iss_d   = iss_q + 1'b1;
        end
        // Word sampled at the end of a ready cycle is written in the following cycle.
        if (ready_q) begin
          mem_en_d    = 1'b1;
          mem_we_d    = 4'hF;
          mem_addr_d  = base_q + MEM_AW'(ret_q);
          mem_wdata_d = bus.bus_wr_data;
          ret_d       = ret_q + 1'b1;
          if (ret_q == BeatLast) state_d = StDone;
        end
      end
      StDone: begin
        if (!bus.bus_as) begin
          rec_valid_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = StIdle;
        end else if (new_req) begin
          accept = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (accept) begin
      rw_d        = bus.bus_rw;
      base_d      = req_addr[MEM_AW+1:2];
      rec_valid_d = 1'b1;
      rec_rw_d    = bus.bus_rw;
      rec_addr_d  = req_addr;
      busy_d      = 1'b1;
      wait_d      = 4'd0;
      if (WAIT_CYCLES == 0) start = 1'b1;
      else state_d = StWait;
    end

    // Beat 0 is launched on the transition edge so the first ready lands WAIT_CYCLES+2
    // cycles after acceptance for reads.
    if (start) begin
      iss_d = BEAT_CNT_W'(1);
      ret_d = '0;
      if (rw_d == READ) begin
        state_d    = StRd;
        mem_en_d   = 1'b1;
        mem_addr_d = base_d;
      end else begin
        state_d = StWr;
        ready_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      rw_q        <= READ;
      base_q      <= '0;
      wait_q      <= '0;
      iss_q       <= '0;
      ret_q       <= '0;
      rd_pend_q   <= 1'b0;
      rec_valid_q <= 1'b0;
      rec_rw_q    <= READ;
      rec_addr_q  <= '0;
      ready_q     <= 1'b0;
      rd_data_q   <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 4'h0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rw_q        <= rw_d;
      base_q      <= base_d;
      wait_q      <= wait_d;
      iss_q       <= iss_d;
      ret_q       <= ret_d;
      rd_pend_q   <= rd_pend_d;
      rec_valid_q <= rec_valid_d;
      rec_rw_q    <= rec_rw_d;
      rec_addr_q  <= rec_addr_d;
      ready_q     <= ready_d;
      rd_data_q   <= rd_data_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.bus_ready   = ready_q;
  assign bus.bus_rd_data = rd_data_q;
  assign mem_en          = mem_en_q;
  assign mem_we          = mem_we_q;
  assign mem_addr        = mem_addr_q;
  assign mem_wdata       = mem_wdata_q;
  assign busy            = busy_q;

endmodule
